// File: rtl/cr16_control_fsm.sv
// rtl/cr16_control_fsm.sv - CR16 fetch/decode/execute instruction sequencer
// Accepts one instruction per handshake and drives registered datapath controls.
module cr16_control_fsm #(
    parameter int IMM_WIDTH = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_RESET,
    input  logic [15:0]          I_INSTR,
    input  logic                 I_INSTR_VALID,
    output logic                 O_INSTR_READY,
    output logic [15:0]          O_REG_ENABLE,
    output logic [3:0]           O_OPCODE,
    output logic                 O_ALU_ENABLE,
    output logic [3:0]           O_READ_PORT_A_SEL,
    output logic [3:0]           O_READ_PORT_B_SEL,
    output logic [15:0]          O_IMMEDIATE,
    output logic                 O_IMM_SEL,
    output logic                 O_ILLEGAL,
    output logic [CNT_WIDTH-1:0] O_RETIRED
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    localparam logic [1:0] CLASS_R   = 2'b00;
    localparam logic [1:0] CLASS_I   = 2'b01;
    localparam logic [1:0] CLASS_CMP = 2'b10;
    localparam logic [1:0] CLASS_BAD = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [15:0] instr_q;
    logic [1:0]  iclass;
    logic        is_itype;
    logic        is_illegal;
    logic [15:0] imm_ext;

    logic        ready_next;
    logic        alu_next;
    logic [15:0] reg_en_next;
    logic        illegal_next;
    logic        load_instr;
    logic        load_decode;
    logic        retire;

    assign iclass   = instr_q[15:14];
    assign is_itype = (iclass == CLASS_I);
    // Reserved bits [1:0] only exist in R and CMP; in I-type they belong to the immediate.
    assign is_illegal = (iclass == CLASS_BAD) ||
                        ((iclass == CLASS_R || iclass == CLASS_CMP) && (instr_q[1:0] != 2'b00));
    assign imm_ext = {{(16-IMM_WIDTH){instr_q[IMM_WIDTH-1]}}, instr_q[IMM_WIDTH-1:0]};

    always_comb begin
        state_next   = state;
        ready_next   = 1'b0;
        alu_next     = 1'b0;
        reg_en_next  = 16'h0000;
        illegal_next = 1'b0;
        load_instr   = 1'b0;
        load_decode  = 1'b0;
        retire       = 1'b0;
        case (state)
            S_FETCH: begin
                // Registered READY is low for one cycle after reset, so gate the accept on it.
                if (O_INSTR_READY && I_INSTR_VALID) begin
                    load_instr = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    ready_next = 1'b1;
                end
            end
            S_DECODE: begin
                load_decode = 1'b1;
                if (is_illegal) begin
                    illegal_next = 1'b1;
                    ready_next   = 1'b1;
                    state_next   = S_FETCH;
                end else begin
                    alu_next    = 1'b1;
                    reg_en_next = (iclass == CLASS_CMP) ? 16'h0000 : (16'h0001 << instr_q[9:6]);
                    state_next  = S_EXEC;
                end
            end
            S_EXEC: begin
                retire     = 1'b1;
                ready_next = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                ready_next = 1'b1;
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state             <= S_FETCH;
            instr_q           <= 16'h0000;
            O_INSTR_READY     <= 1'b0;
            O_REG_ENABLE      <= 16'h0000;
            O_OPCODE          <= 4'h0;
            O_ALU_ENABLE      <= 1'b0;
            O_READ_PORT_A_SEL <= 4'h0;
            O_READ_PORT_B_SEL <= 4'h0;
            O_IMMEDIATE       <= 16'h0000;
            O_IMM_SEL         <= 1'b0;
            O_ILLEGAL         <= 1'b0;
            O_RETIRED         <= '0;
        end else begin
            state         <= state_next;
            O_INSTR_READY <= ready_next;
            O_ALU_ENABLE  <= alu_next;
            O_REG_ENABLE  <= reg_en_next;
            O_ILLEGAL     <= illegal_next;
            if (load_instr) begin
                instr_q <= I_INSTR;
            end
            if (load_decode) begin
                O_OPCODE          <= instr_q[13:10];
                O_READ_PORT_A_SEL <= instr_q[9:6];
                O_READ_PORT_B_SEL <= instr_q[5:2];
                O_IMMEDIATE       <= is_itype ? imm_ext : 16'h0000;
                O_IMM_SEL         <= is_itype;
            end
            if (retire) begin
                O_RETIRED <= O_RETIRED + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// tb/tb_cr16_control_fsm.sv - directed table-driven bench for cr16_control_fsm
module tb_cr16_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] reg_en;
    logic [3:0]  opcode;
    logic        alu_en;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [15:0] imm;
    logic        imm_sel;
    logic        illegal;
    logic [15:0] retired;

    logic [15:0] instr2 = 16'h8000;
    logic        valid2 = 1'b0;
    logic        ready2;
    logic [15:0] reg_en2;
    logic [3:0]  opcode2;
    logic        alu_en2;
    logic [3:0]  sel_a2;
    logic [3:0]  sel_b2;
    logic [15:0] imm2;
    logic        imm_sel2;
    logic        illegal2;
    logic [3:0]  retired2;

    cr16_control_fsm dut (
        .I_CLK(clk), .I_RESET(rst), .I_INSTR(instr), .I_INSTR_VALID(valid),
        .O_INSTR_READY(ready), .O_REG_ENABLE(reg_en), .O_OPCODE(opcode),
        .O_ALU_ENABLE(alu_en), .O_READ_PORT_A_SEL(sel_a), .O_READ_PORT_B_SEL(sel_b),
        .O_IMMEDIATE(imm), .O_IMM_SEL(imm_sel), .O_ILLEGAL(illegal), .O_RETIRED(retired)
    );

    // Narrow counter instance so the wrap-around is reachable in a short run.
    cr16_control_fsm #(.IMM_WIDTH(6), .CNT_WIDTH(4)) dut_w4 (
        .I_CLK(clk), .I_RESET(rst), .I_INSTR(instr2), .I_INSTR_VALID(valid2),
        .O_INSTR_READY(ready2), .O_REG_ENABLE(reg_en2), .O_OPCODE(opcode2),
        .O_ALU_ENABLE(alu_en2), .O_READ_PORT_A_SEL(sel_a2), .O_READ_PORT_B_SEL(sel_b2),
        .O_IMMEDIATE(imm2), .O_IMM_SEL(imm_sel2), .O_ILLEGAL(illegal2), .O_RETIRED(retired2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        bad;
        logic [15:0] reg_en;
        logic [3:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] imm;
        logic        imm_sel;
    } vec_t;

    vec_t vecs[9];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int accepts[4];
        int k;
        int reg_pulses;
        int alu_pulses;
        logic [15:0] b2b[4];

        vecs[0] = '{16'h1288, 1'b0, 16'h0400, 4'd4,  4'd10, 4'd2,  16'h0000, 1'b0};
        vecs[1] = '{16'h407F, 1'b0, 16'h0002, 4'd0,  4'd1,  4'd15, 16'hFFFF, 1'b1};
        vecs[2] = '{16'h8000, 1'b0, 16'h0000, 4'd0,  4'd0,  4'd0,  16'h0000, 1'b0};
        vecs[3] = '{16'hC000, 1'b1, 16'h0000, 4'd0,  4'd0,  4'd0,  16'h0000, 1'b0};
        vecs[4] = '{16'h0001, 1'b1, 16'h0000, 4'd0,  4'd0,  4'd0,  16'h0000, 1'b0};
        vecs[5] = '{16'h3FFC, 1'b0, 16'h8000, 4'd15, 4'd15, 4'd15, 16'h0000, 1'b0};
        vecs[6] = '{16'h5C1F, 1'b0, 16'h0001, 4'd7,  4'd0,  4'd7,  16'h001F, 1'b1};
        vecs[7] = '{16'h8002, 1'b1, 16'h0000, 4'd0,  4'd0,  4'd0,  16'h0000, 1'b0};
        vecs[8] = '{16'h4020, 1'b0, 16'h0001, 4'd0,  4'd0,  4'd8,  16'hFFE0, 1'b1};

        step();
        step();
        rst = 1'b0;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_reg_en", {16'd0, reg_en}, 32'd0);
        chk("rst_retired", {16'd0, retired}, 32'd0);
        step();
        chk("post_rst_ready", {31'd0, ready}, 32'd1);

        // Reset asserted in the middle of EXEC aborts the instruction.
        instr = 16'h1288;
        valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        chk("pre_abort_alu_en", {31'd0, alu_en}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("abort_reg_en", {16'd0, reg_en}, 32'd0);
        chk("abort_alu_en", {31'd0, alu_en}, 32'd0);
        chk("abort_retired", {16'd0, retired}, 32'd0);
        #1 rst = 1'b0;
        step();
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_not_counted", {16'd0, retired}, 32'd0);

        foreach (vecs[i]) begin
            wait_ready();
            instr = vecs[i].instr;
            valid = 1'b1;
            step();
            valid = 1'b0;
            chk($sformatf("v%0d_decode_ready", i), {31'd0, ready}, 32'd0);
            chk($sformatf("v%0d_decode_alu", i), {31'd0, alu_en}, 32'd0);
            step();
            if (!vecs[i].bad) begin
                model_cnt++;
                chk($sformatf("v%0d_alu_en", i), {31'd0, alu_en}, 32'd1);
                chk($sformatf("v%0d_reg_en", i), {16'd0, reg_en}, {16'd0, vecs[i].reg_en});
                chk($sformatf("v%0d_opcode", i), {28'd0, opcode}, {28'd0, vecs[i].op});
                chk($sformatf("v%0d_sel_a", i), {28'd0, sel_a}, {28'd0, vecs[i].a});
                if (!vecs[i].imm_sel)
                    chk($sformatf("v%0d_sel_b", i), {28'd0, sel_b}, {28'd0, vecs[i].b});
                chk($sformatf("v%0d_imm", i), {16'd0, imm}, {16'd0, vecs[i].imm});
                chk($sformatf("v%0d_imm_sel", i), {31'd0, imm_sel}, {31'd0, vecs[i].imm_sel});
                chk($sformatf("v%0d_exec_ready", i), {31'd0, ready}, 32'd0);
                step();
                chk($sformatf("v%0d_retired", i), {16'd0, retired}, model_cnt);
                chk($sformatf("v%0d_fetch_ready", i), {31'd0, ready}, 32'd1);
                chk($sformatf("v%0d_fetch_reg_en", i), {16'd0, reg_en}, 32'd0);
                chk($sformatf("v%0d_fetch_alu", i), {31'd0, alu_en}, 32'd0);
            end else begin
                chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, 32'd1);
                chk($sformatf("v%0d_ill_ready", i), {31'd0, ready}, 32'd1);
                chk($sformatf("v%0d_ill_alu", i), {31'd0, alu_en}, 32'd0);
                chk($sformatf("v%0d_ill_reg_en", i), {16'd0, reg_en}, 32'd0);
                chk($sformatf("v%0d_ill_retired", i), {16'd0, retired}, model_cnt);
                step();
                chk($sformatf("v%0d_illegal_pulse", i), {31'd0, illegal}, 32'd0);
            end
        end

        // Back-to-back: VALID held high across four instructions.
        b2b[0] = 16'h1288;
        b2b[1] = 16'h0444;
        b2b[2] = 16'h8000;
        b2b[3] = 16'h407F;
        k = 0;
        reg_pulses = 0;
        alu_pulses = 0;
        wait_ready();
        instr = b2b[0];
        valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (reg_en != 16'h0000) reg_pulses++;
            if (alu_en) alu_pulses++;
            if (ready && valid) begin
                accepts[k] = cyc;
                k++;
                step();
                if (k < 4) instr = b2b[k];
                else valid = 1'b0;
            end else begin
                step();
            end
        end
        valid = 1'b0;
        chk("b2b_accepts", k, 4);
        for (int i = 1; i < 4; i++)
            if (i < k) chk($sformatf("b2b_spacing%0d", i), accepts[i] - accepts[i-1], 3);
        chk("b2b_reg_pulses", reg_pulses, 3);
        chk("b2b_alu_pulses", alu_pulses, 4);
        model_cnt += 4;
        chk("b2b_retired", {16'd0, retired}, model_cnt);

        // Counter wrap on the narrow instance.
        valid2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            step();
            step();
            if (i == 14) chk("wrap_pre", {28'd0, retired2}, 32'd15);
        end
        valid2 = 1'b0;
        chk("wrap_zero", {28'd0, retired2}, 32'd0);
        chk("wrap_illegal", {31'd0, illegal2}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
